// File: rtl/framebuffer_store_pkg.sv
// Shared framebuffer geometry, store FSM encodings and the RAM write payload.
// Both ends of the LED-matrix framebuffer RAM import this package.
package framebuffer_store_pkg;

   localparam int unsigned COLUMN_BITS    = 6;
   localparam int unsigned ROW_BITS       = 4;
   localparam int unsigned Y_BITS         = ROW_BITS + 1;
   localparam int unsigned PIXEL_BITS     = COLUMN_BITS + Y_BITS;
   localparam int unsigned RAM_ADDR_WIDTH = 11;
   localparam int unsigned PIXEL_COUNT    = 2048;
   localparam int unsigned PIXEL_WIDTH    = 16;
   localparam int unsigned BYTE_WIDTH     = 8;

   typedef enum logic [1:0] {
      ST_HI    = 2'd0,
      ST_LO    = 2'd1,
      ST_WRITE = 2'd2
   } store_state_t;

   typedef struct packed {
      logic [RAM_ADDR_WIDTH-1:0] address;
      logic [PIXEL_WIDTH-1:0]    data;
   } ram_write_t;

   function automatic logic is_last_pixel(input logic [PIXEL_BITS-1:0] pixel);
      return pixel == PIXEL_BITS'(PIXEL_COUNT - 1);
   endfunction

endpackage

// File: rtl/framebuffer_store_address_map.sv
// Raster position {x,y} to framebuffer RAM address {half, row, column field}.
// The column field is inverted when MIRROR_COLUMNS is set so it matches the fetch side.
module framebuffer_store_address_map
   import framebuffer_store_pkg::*;
#(
   parameter bit MIRROR_COLUMNS = 1'b1
) (
   input  logic [COLUMN_BITS-1:0]    x,
   input  logic [Y_BITS-1:0]         y,
   output logic [RAM_ADDR_WIDTH-1:0] address_c
);

   logic                   half;
   logic [ROW_BITS-1:0]    row;
   logic [COLUMN_BITS-1:0] column_field;

   assign half         = y[ROW_BITS];
   assign row          = y[ROW_BITS-1:0];
   assign column_field = MIRROR_COLUMNS ? ~x : x;
   assign address_c    = {half, row, column_field};

endmodule

// File: rtl/framebuffer_store.sv
// Write side of the LED-matrix framebuffer: assembles RGB565 pixels from a
// high-byte-first stream and writes them in raster order, one RAM write per pixel.
module framebuffer_store
   import framebuffer_store_pkg::*;
#(
   parameter bit MIRROR_COLUMNS = 1'b1
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        frame_start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [10:0] ram_address,
   output logic [15:0] ram_data_out,
   output logic        ram_write_enable,
   output logic        ram_clk_enable,
   output logic        frame_complete,
   output logic        overrun
);

   store_state_t state;
   store_state_t next_state;

   logic [PIXEL_BITS-1:0]     pixel_q;
   logic [PIXEL_BITS-1:0]     pixel_d;
   logic [BYTE_WIDTH-1:0]     hi_q;
   logic [BYTE_WIDTH-1:0]     hi_d;
   ram_write_t                wr_q;
   ram_write_t                wr_d;
   logic                      write_q;
   logic                      write_d;
   logic                      complete_q;
   logic                      complete_d;
   logic                      ready_q;
   logic                      ready_d;
   logic                      overrun_q;
   logic                      overrun_d;
   logic                      accept_c;
   logic [RAM_ADDR_WIDTH-1:0] pixel_address_c;

   // frame_start wins over a byte arriving in the same cycle
   assign accept_c = rx_valid & ready_q & ~frame_start;

   framebuffer_store_address_map #(
      .MIRROR_COLUMNS(MIRROR_COLUMNS)
   ) u_address_map (
      .x         (pixel_q[COLUMN_BITS-1:0]),
      .y         (pixel_q[PIXEL_BITS-1:COLUMN_BITS]),
      .address_c (pixel_address_c)
   );

   always_ff @(posedge clk_in) begin
      if (reset) state <= ST_HI;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (frame_start) begin
         next_state = ST_HI;
      end else begin
         case (state)
            ST_HI:    if (accept_c) next_state = ST_LO;
            ST_LO:    if (accept_c) next_state = ST_WRITE;
            ST_WRITE: next_state = ST_HI;
            default:  next_state = ST_HI;
         endcase
      end
   end

   // Next values of every registered output, derived from the transition being taken
   always_comb begin
      ready_d    = (next_state != ST_WRITE);
      write_d    = (next_state == ST_WRITE);
      complete_d = write_d & is_last_pixel(pixel_q);

      wr_d = wr_q;
      if (write_d) begin
         wr_d.address = pixel_address_c;
         wr_d.data    = {hi_q, rx_data};
      end

      // A write in flight still completes on frame_start, but the pointer restarts at 0
      pixel_d = pixel_q;
      if (frame_start)             pixel_d = '0;
      else if (state == ST_WRITE)  pixel_d = pixel_q + PIXEL_BITS'(1);

      hi_d = hi_q;
      if (frame_start)                      hi_d = '0;
      else if (state == ST_HI && accept_c)  hi_d = rx_data;

      overrun_d = overrun_q;
      if (frame_start)                overrun_d = 1'b0;
      else if (rx_valid && !ready_q)  overrun_d = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         pixel_q    <= '0;
         hi_q       <= '0;
         wr_q       <= '0;
         write_q    <= 1'b0;
         complete_q <= 1'b0;
         ready_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         pixel_q    <= pixel_d;
         hi_q       <= hi_d;
         wr_q       <= wr_d;
         write_q    <= write_d;
         complete_q <= complete_d;
         ready_q    <= ready_d;
         overrun_q  <= overrun_d;
      end
   end

   assign rx_ready         = ready_q;
   assign ram_address      = wr_q.address;
   assign ram_data_out     = wr_q.data;
   assign ram_write_enable = write_q;
   assign ram_clk_enable   = write_q;
   assign frame_complete   = complete_q;
   assign overrun          = overrun_q;

endmodule

// File: tb/tb_framebuffer_store.sv
// Self-checking bench for framebuffer_store: a mirrored and an unmirrored instance
// share one byte stream; expected writes are queued and popped as writes appear.
module tb_framebuffer_store;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;

   logic        ready_m, we_m, ce_m, fc_m, ovr_m;
   logic [10:0] addr_m;
   logic [15:0] data_m;
   logic        ready_n, we_n, ce_n, fc_n, ovr_n;
   logic [10:0] addr_n;
   logic [15:0] data_n;

   framebuffer_store #(.MIRROR_COLUMNS(1'b1)) dut_m (
      .clk_in(clk), .reset(reset), .frame_start(frame_start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(ready_m),
      .ram_address(addr_m), .ram_data_out(data_m), .ram_write_enable(we_m),
      .ram_clk_enable(ce_m), .frame_complete(fc_m), .overrun(ovr_m)
   );

   framebuffer_store #(.MIRROR_COLUMNS(1'b0)) dut_n (
      .clk_in(clk), .reset(reset), .frame_start(frame_start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(ready_n),
      .ram_address(addr_n), .ram_data_out(data_n), .ram_write_enable(we_n),
      .ram_clk_enable(ce_n), .frame_complete(fc_n), .overrun(ovr_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] addr_m;
      logic [10:0] addr_n;
      logic [15:0] data;
      logic        fc;
   } exp_t;

   typedef struct {
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic [10:0] addr_m;
      logic [10:0] addr_n;
      logic        fc;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t tbl[4];
   int   n_vec = 0;
   int   n_err = 0;
   bit   track_hits = 1'b0;
   bit   hit[2048];
   int   hit_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] map_addr(input int p, input bit mirror);
      logic [5:0] x;
      logic [4:0] y;
      x = 6'(p % 64);
      y = 5'(p / 64);
      return {y, (mirror ? ~x : x)};
   endfunction

   // Scoreboard consumer: every write strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (we_m || ce_m || fc_m || we_n || ce_n || fc_n) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h we %0d fc %0d, want no write",
                     addr_m, data_m, we_m, fc_m);
         end else begin
            mon_e = sb.pop_front();
            check("write_enable", 32'(we_m), 32'd1);
            check("clk_enable", 32'(ce_m), 32'd1);
            check("addr", 32'(addr_m), 32'(mon_e.addr_m));
            check("data", 32'(data_m), 32'(mon_e.data));
            check("frame_complete", 32'(fc_m), 32'(mon_e.fc));
            check("addr_nomirror", 32'(addr_n), 32'(mon_e.addr_n));
            check("data_nomirror", 32'(data_n), 32'(mon_e.data));
            check("we_nomirror", 32'(we_n), 32'd1);
            if (track_hits && !hit[addr_m]) begin
               hit[addr_m] = 1'b1;
               hit_count++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      while (!ready_m && guard < 10) begin
         tick();
         guard++;
      end
      if (!ready_m) begin
         n_vec++;
         n_err++;
         $display("FAIL rx_ready_timeout: rx_ready %0d, want 1", ready_m);
      end
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic push(input logic [10:0] am, input logic [10:0] an,
                       input logic [15:0] d, input logic fc);
      exp_t e;
      e.addr_m = am;
      e.addr_n = an;
      e.data   = d;
      e.fc     = fc;
      sb.push_back(e);
   endtask

   task automatic send_pixel(input logic [15:0] d);
      send_byte(d[15:8]);
      send_byte(d[7:0]);
   endtask

   task automatic send_model(input int p, input logic [15:0] d);
      push(map_addr(p, 1'b1), map_addr(p, 1'b0), d, (p == 2047));
      send_pixel(d);
   endtask

   task automatic pulse_frame_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         tick();
         guard++;
      end
      tick();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{hi: 8'hF8, lo: 8'h00, addr_m: 11'h03F, addr_n: 11'h000, fc: 1'b0};
      tbl[1] = '{hi: 8'h12, lo: 8'h34, addr_m: 11'h03E, addr_n: 11'h001, fc: 1'b0};
      tbl[2] = '{hi: 8'hFF, lo: 8'hFF, addr_m: 11'h03D, addr_n: 11'h002, fc: 1'b0};
      tbl[3] = '{hi: 8'h07, lo: 8'hE0, addr_m: 11'h03C, addr_n: 11'h003, fc: 1'b0};

      // Reset values
      reset = 1'b1;
      repeat (3) tick();
      check("reset_ready", 32'(ready_m), 32'd0);
      check("reset_addr", 32'(addr_m), 32'd0);
      check("reset_data", 32'(data_m), 32'd0);
      check("reset_we", 32'(we_m), 32'd0);
      check("reset_ce", 32'(ce_m), 32'd0);
      check("reset_fc", 32'(fc_m), 32'd0);
      check("reset_overrun", 32'(ovr_m), 32'd0);
      reset = 1'b0;
      tick();
      check("ready_after_reset", 32'(ready_m), 32'd1);

      // Table-driven first pixels of a frame
      pulse_frame_start();
      for (int i = 0; i < 4; i++) begin
         push(tbl[i].addr_m, tbl[i].addr_n, {tbl[i].hi, tbl[i].lo}, tbl[i].fc);
         send_byte(tbl[i].hi);
         send_byte(tbl[i].lo);
      end
      drain();
      repeat (3) tick();
      check("hold_addr", 32'(addr_m), 32'h03C);
      check("hold_data", 32'(data_m), 32'h07E0);
      check("no_overrun", 32'(ovr_m), 32'd0);

      // Latency and overrun: byte arriving in the write cycle is dropped
      pulse_frame_start();
      push(11'h03F, 11'h000, 16'h1357, 1'b0);
      send_byte(8'h13);
      rx_data  = 8'h57;
      rx_valid = 1'b1;
      tick();
      check("write_cycle_we", 32'(we_m), 32'd1);
      check("write_cycle_ready", 32'(ready_m), 32'd0);
      rx_data = 8'hEE;
      tick();
      rx_valid = 1'b0;
      check("ready_after_write", 32'(ready_m), 32'd1);
      check("overrun_set", 32'(ovr_m), 32'd1);
      push(11'h03E, 11'h001, 16'h2468, 1'b0);
      send_pixel(16'h2468);
      drain();
      check("overrun_sticky", 32'(ovr_m), 32'd1);
      pulse_frame_start();
      check("overrun_cleared", 32'(ovr_m), 32'd0);

      // frame_start together with rx_valid after only the hi byte
      send_byte(8'hAB);
      frame_start = 1'b1;
      rx_valid    = 1'b1;
      rx_data     = 8'hCD;
      tick();
      frame_start = 1'b0;
      rx_valid    = 1'b0;
      check("fs_beats_valid_overrun", 32'(ovr_m), 32'd0);
      repeat (3) tick();
      push(11'h03F, 11'h000, 16'h5A5A, 1'b0);
      send_pixel(16'h5A5A);
      drain();

      // Sync reset between hi and lo byte
      send_byte(8'h99);
      reset = 1'b1;
      tick();
      check("midreset_we", 32'(we_m), 32'd0);
      check("midreset_addr", 32'(addr_m), 32'd0);
      check("midreset_data", 32'(data_m), 32'd0);
      check("midreset_ready", 32'(ready_m), 32'd0);
      reset = 1'b0;
      tick();
      push(11'h03F, 11'h000, 16'h0F0F, 1'b0);
      send_pixel(16'h0F0F);
      drain();

      // Pixel (x=5,y=3): mirrored 0x0FA, unmirrored 0x0C5
      pulse_frame_start();
      for (int p = 0; p < 197; p++) send_model(p, 16'(p));
      push(11'h0FA, 11'h0C5, 16'hBEEF, 1'b0);
      send_pixel(16'hBEEF);
      drain();

      // Full frame with data = p, then wrap into the next frame
      pulse_frame_start();
      track_hits = 1'b1;
      for (int p = 0; p < 2048; p++) begin
         if (p == 1024) begin
            push(11'h43F, 11'h400, 16'(p), 1'b0);
            send_pixel(16'(p));
         end else begin
            send_model(p, 16'(p));
         end
      end
      drain();
      track_hits = 1'b0;
      check("distinct_addresses", 32'(hit_count), 32'd2048);
      push(11'h03F, 11'h000, 16'hAAAA, 1'b0);
      send_pixel(16'hAAAA);
      drain();
      check("final_overrun", 32'(ovr_m), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
